// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues imem reads, waits MEM_LATENCY cycles and
// holds each instruction for decode. Defining FETCH_STEP_EN adds the single-step input.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    INSTR_WIDTH  = 32,
    parameter int                    MEM_LATENCY  = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    output logic                   imem_rd,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic [ADDR_WIDTH-1:0]  pc
`ifdef FETCH_STEP_EN
    ,
    input  logic                   step
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    state_t                 state, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0]  instr_pc_q;
    logic [3:0]             count_q, count_d;
    logic                   capture;
    logic                   start;

`ifdef FETCH_STEP_EN
    // Two synchroniser flops plus one history flop for rising-edge detection.
    logic [2:0] step_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_sync <= '0;
        end else begin
            step_sync <= {step_sync[1:0], step};
        end
    end

    assign start = run | (step_sync[1] & ~step_sync[2]);
`else
    assign start = run;
`endif

    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        count_d = count_q;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                count_d = LAT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (count_q == 4'd0) begin
                    capture = 1'b1;
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = ST_HOLD;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    state_d = run ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect overrides everything: any outstanding read is abandoned and its data never captured.
        if (redirect_valid) begin
            capture = 1'b0;
            pc_d    = redirect_addr & ~ADDR_WIDTH'(3);
            state_d = run ? ST_ISSUE : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state   <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            if (state_d == ST_ISSUE) begin
                addr_q <= pc_d;
            end
            if (capture) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= addr_q;
            end
        end
    end

    assign imem_rd     = (state == ST_ISSUE);
    assign imem_addr   = addr_q;
    assign instr_valid = (state == ST_HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic checked
// against a transaction-level model of the accepted instruction stream.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
`ifdef FETCH_STEP_EN
    logic        step = 1'b0;
`endif

    logic        reset4 = 1'b0;
    logic        run4 = 1'b0;
    logic        imem_rd4;
    logic [31:0] imem_addr4;
    logic [31:0] imem_rdata4;
    logic        instr_valid4;
    logic [31:0] instr4;
    logic [31:0] instr_pc4;
    logic [31:0] pc4;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_accept = 0;
    int          n_rd = 0;
    logic [31:0] exp_next = '0;
    logic        hold_pending = 1'b0;
    logic [31:0] held_instr = '0;
    logic [31:0] held_pc = '0;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .MEM_LATENCY(1), .RESET_VECTOR(32'h0)) u_dut (
        .clk(clk), .reset(reset), .run(run),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .pc(pc)
`ifdef FETCH_STEP_EN
        , .step(step)
`endif
    );

    fetch_sequencer #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .MEM_LATENCY(4), .RESET_VECTOR(32'h0)) u_dut4 (
        .clk(clk), .reset(reset4), .run(run4),
        .redirect_valid(1'b0), .redirect_addr(32'h0),
        .imem_rd(imem_rd4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
        .instr_valid(instr_valid4), .instr_ready(1'b1),
        .instr(instr4), .instr_pc(instr_pc4), .pc(pc4)
`ifdef FETCH_STEP_EN
        , .step(1'b0)
`endif
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a >> 2;
    endfunction

    function automatic logic [31:0] memWord4(input logic [31:0] a);
        return (a >> 2) ^ 32'hA5A5_0000;
    endfunction

    // Memories present valid data only exactly LATENCY cycles after the read strobe.
    int          age1 = 0;
    int          age4 = 0;
    logic [31:0] raddr1 = '0;
    logic [31:0] raddr4 = '0;

    always @(posedge clk) begin
        if (imem_rd) begin
            age1   <= 1;
            raddr1 <= imem_addr;
        end else if (age1 != 0 && age1 < 64) begin
            age1 <= age1 + 1;
        end
        if (imem_rd4) begin
            age4   <= 1;
            raddr4 <= imem_addr4;
        end else if (age4 != 0 && age4 < 64) begin
            age4 <= age4 + 1;
        end
    end

    assign imem_rdata  = (age1 == 1) ? memWord(raddr1) : 32'hDEAD_BEEF;
    assign imem_rdata4 = (age4 == 4) ? memWord4(raddr4) : 32'hDEAD_BEEF;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Stream model: accepted instructions are consecutive words from the last redirect target.
    task automatic modelStep();
        if (hold_pending) begin
            checkOutput("hold_valid", instr_valid, 1'b1);
            checkOutput("hold_instr", instr, held_instr);
            checkOutput("hold_pc", instr_pc, held_pc);
        end
        if (imem_rd === 1'b1) n_rd++;
        if (instr_valid === 1'b1 && instr_ready) begin
            checkOutput("accept_pc", instr_pc, exp_next);
            checkOutput("accept_instr", instr, memWord(exp_next));
            exp_next = exp_next + 32'd4;
            n_accept++;
        end
        hold_pending = (instr_valid === 1'b1) && !instr_ready && !redirect_valid;
        held_instr   = instr;
        held_pc      = instr_pc;
        if (redirect_valid) exp_next = redirect_addr & ~32'h3;
    endtask

    task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] ra, input logic rdy);
        run            = r;
        redirect_valid = rv;
        redirect_addr  = ra;
        instr_ready    = rdy;
        modelStep();
        @(negedge clk);
    endtask

    task automatic resetDut1();
        run            = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        reset          = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_imem_rd", imem_rd, 1'b0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_valid", instr_valid, 1'b0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        exp_next     = '0;
        hold_pending = 1'b0;
        reset        = 1'b1;
    endtask

    initial begin
        int acc0;
        int rd0;
        $display("[TB] start");
        resetDut1();

        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput("t1_imem_rd", imem_rd, (i % 3) == 1);
            checkOutput("t1_valid", instr_valid, (i % 3) == 0);
            if (i == 1) checkOutput("t1_first_addr", imem_addr, 32'h0);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            checkOutput("t2_no_rd", imem_rd, 1'b0);
            checkOutput("t2_valid", instr_valid, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("t2_release_rd", imem_rd, 1'b1);
        checkOutput("t2_release_addr", imem_addr, 32'hC);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("t3_wait_rd", imem_rd, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h103, 1'b1);
        checkOutput("t3_redir_rd", imem_rd, 1'b1);
        checkOutput("t3_redir_addr", imem_addr, 32'h100);
        checkOutput("t3_redir_pc", pc, 32'h100);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("t3_discard_valid", instr_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("t3_hold_valid", instr_valid, 1'b1);
        checkOutput("t3_instr_pc", instr_pc, 32'h100);
        checkOutput("t3_instr", instr, 32'h40);
        checkOutput("t3_pc", pc, 32'h104);

        acc0 = n_accept;
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
        checkOutput("t4_accept_once", n_accept - acc0, 1);
        checkOutput("t4_valid_drop", instr_valid, 1'b0);
        checkOutput("t4_rd", imem_rd, 1'b1);
        checkOutput("t4_addr", imem_addr, 32'h200);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("t4_hold_pc", instr_pc, 32'h200);
        acc0 = n_accept;
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b0);
        checkOutput("t4_no_accept", n_accept - acc0, 0);
        checkOutput("t4_drop_valid", instr_valid, 1'b0);
        checkOutput("t4_drop_addr", imem_addr, 32'h300);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("run0_wait_valid", instr_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("run0_hold_valid", instr_valid, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("run0_idle_valid", instr_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("run0_idle_rd", imem_rd, 1'b0);
        checkOutput("run0_pc", pc, 32'h304);

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        checkOutput("t5_wrap_start_pc", pc, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("t5_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t5_wrap_pc", pc, 32'h0);
        checkOutput("t5_wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t5_wrap_idle", instr_valid, 1'b0);

        acc0 = n_accept;
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 6, $urandom,
                          $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        end
        checkOutput("rand_progress", (n_accept - acc0) > 20, 1'b1);
        checkOutput("rand_drain_valid", instr_valid, 1'b0);
        checkOutput("rand_drain_rd", imem_rd, 1'b0);

`ifdef FETCH_STEP_EN
        resetDut1();
        for (int p = 0; p < 3; p++) begin
            rd0  = n_rd;
            acc0 = n_accept;
            step = 1'b1;
            for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            step = 1'b0;
            for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("step_one_rd", n_rd - rd0, 1);
            checkOutput("step_one_accept", n_accept - acc0, 1);
            checkOutput("step_idle_valid", instr_valid, 1'b0);
            checkOutput("step_idle_rd", imem_rd, 1'b0);
        end
        checkOutput("step_pc", pc, 32'hC);
`else
        rd0 = n_rd;
        checkOutput("rd_count_seen", rd0 > 0, 1'b1);
`endif

        run4   = 1'b1;
        reset4 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checkOutput("lat4_rd", imem_rd4, i == 1);
            checkOutput("lat4_valid", instr_valid4, i == 6);
        end
        checkOutput("lat4_instr", instr4, memWord4(32'h0));
        checkOutput("lat4_instr_pc", instr_pc4, 32'h0);
        checkOutput("lat4_pc", pc4, 32'h4);
        @(negedge clk);
        checkOutput("lat4_next_rd", imem_rd4, 1'b1);
        checkOutput("lat4_next_addr", imem_addr4, 32'h4);
        @(negedge clk);
        @(negedge clk);
        reset4 = 1'b0;
        #1;
        checkOutput("mid_rst_rd", imem_rd4, 1'b0);
        checkOutput("mid_rst_addr", imem_addr4, 32'h0);
        checkOutput("mid_rst_valid", instr_valid4, 1'b0);
        checkOutput("mid_rst_instr", instr4, 32'h0);
        checkOutput("mid_rst_instr_pc", instr_pc4, 32'h0);
        checkOutput("mid_rst_pc", pc4, 32'h0);
        @(negedge clk);
        reset4 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checkOutput("post_rst_valid", instr_valid4, i == 6);
        end
        checkOutput("post_rst_instr_pc", instr_pc4, 32'h0);
        checkOutput("post_rst_instr", instr4, memWord4(32'h0));
        reset4 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
